// File: rtl/sipo_pkg.sv
// Purpose : shared types and constants for the serial-in/parallel-out deserializer.
// Latency : n/a (package only).
// Backpress: n/a (package only).
// Optional feature macro: SIPO_PARITY_EN adds the PAR state used for the trailing parity bit.
package sipo_pkg;

    // Default number of data bits per assembled word.
    localparam int SIPO_WIDTH_DEF = 4;

`ifdef SIPO_PARITY_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
    } state_t;
`endif

endpackage

// File: rtl/sipo_bitcnt.sv
// Purpose : data-bit counter for sipo_deser; flags the bit that completes a word.
// Latency : last is combinational from the registered count (same cycle as the bit).
// Backpress: none; counts every step pulse, wraps to 0 after WIDTH bits.
// Ports   : clk, rst (sync, active-high), clr (zero count), step (count one bit),
//           last (the bit being stepped now is data bit WIDTH).
module sipo_bitcnt #(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic step,
    output logic last
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign last = (cnt_q == LAST_IDX);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (step) begin
            // Wrap on the completing bit so back-to-back words need no idle cycle.
            cnt_d = last ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sipo_deser.sv
// Purpose : serial-in/parallel-out deserializer, MSB first, with a one-word holding register.
// Latency : out/out_valid update on the edge that samples the completing bit.
// Backpress: out_valid holds until out_ready; a word completing into a full, undrained
//            holding register is dropped and sets the sticky overrun flag.
// Ports   : clk, rst (sync, active-high); in/en serial bit + strobe; clr frame restart;
//           out/out_valid/out_ready word handshake; overrun sticky drop flag;
//           parity_err only when SIPO_PARITY_EN is defined (even parity bit follows data).
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef SIPO_PARITY_EN
    output logic             parity_err,
`endif
    output logic             overrun
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             overrun_q, overrun_d;
`ifdef SIPO_PARITY_EN
    logic             parity_err_q, parity_err_d;
    logic             new_perr;
`endif

    logic             take;       // bit accepted this cycle (clr wins over en)
    logic             data_take;  // accepted bit is a data bit (goes into sreg/counter)
    logic             last;
    logic             word_done;
    logic [WIDTH-1:0] new_word;

    assign take = en & ~clr;
`ifdef SIPO_PARITY_EN
    assign data_take = take & (state_q != PAR);
`else
    assign data_take = take;
`endif

    sipo_bitcnt #(
        .WIDTH (WIDTH)
    ) u_bitcnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .step (data_take),
        .last (last)
    );

    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;
        word_done   = 1'b0;
        new_word    = sreg_q;
`ifdef SIPO_PARITY_EN
        parity_err_d = parity_err_q;
        new_perr     = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (data_take) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (clr) begin
                    state_d = IDLE;
                end else if (data_take && last) begin
`ifdef SIPO_PARITY_EN
                    // Data complete; word is released on the parity bit.
                    state_d = PAR;
`else
                    state_d   = IDLE;
                    word_done = 1'b1;
                    new_word  = {sreg_q[WIDTH-2:0], in};
`endif
                end
            end
`ifdef SIPO_PARITY_EN
            PAR: begin
                if (clr) begin
                    state_d = IDLE;
                end else if (take) begin
                    state_d   = IDLE;
                    word_done = 1'b1;
                    new_word  = sreg_q;
                    new_perr  = ^{sreg_q, in};
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        if (clr) begin
            sreg_d = '0;
        end else if (data_take) begin
            sreg_d = {sreg_q[WIDTH-2:0], in};
        end

        // Drain first; a completing word may reload the register on the same edge.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (word_done) begin
            if (!out_valid_q || out_ready) begin
                out_d       = new_word;
                out_valid_d = 1'b1;
`ifdef SIPO_PARITY_EN
                parity_err_d = new_perr;
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sreg_q      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef SIPO_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
`ifdef SIPO_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;
`ifdef SIPO_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_sipo_deser.sv
// Purpose : directed self-checking bench for sipo_deser at WIDTH=4.
// Latency : checks sample outputs 1 time unit after each rising edge.
// Backpress: exercises out_ready low (hold/overrun) and high (drain/reload).
module tb_sipo_deser;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in = 1'b0;
    logic       en = 1'b0;
    logic       clr = 1'b0;
    logic       out_ready = 1'b1;
    logic [3:0] out;
    logic       out_valid;
    logic       overrun;
`ifdef SIPO_PARITY_EN
    logic       parity_err;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sipo_deser #(
        .WIDTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in         (in),
        .en         (en),
        .clr        (clr),
        .out        (out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
`ifdef SIPO_PARITY_EN
        .parity_err (parity_err),
`endif
        .overrun    (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs are stable for checking when this returns.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic b);
        en = 1'b1;
        in = b;
        step();
        en = 1'b0;
        in = 1'b0;
    endtask

    task automatic send_word(input logic [3:0] w);
        for (int i = 3; i >= 0; i--) begin
            send(w[i]);
        end
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_out", 32'(out), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);

        // Basic word 1011 with consumer ready
        out_ready = 1'b1;
        send(1'b1);
        send(1'b0);
        send(1'b1);
        chk("s1_no_early_valid", 32'(out_valid), 32'h0);
        send(1'b1);
        chk("s1_valid", 32'(out_valid), 32'h1);
        chk("s1_out", 32'(out), 32'hB);
        step();
        chk("s1_drained", 32'(out_valid), 32'h0);

        // Consumer stalled: hold, then overrun on second word
        out_ready = 1'b0;
        send_word(4'b1011);
        chk("s2_w1_valid", 32'(out_valid), 32'h1);
        chk("s2_w1_out", 32'(out), 32'hB);
        chk("s2_w1_no_overrun", 32'(overrun), 32'h0);
        step();
        step();
        chk("s2_hold_valid", 32'(out_valid), 32'h1);
        send_word(4'b0101);
        chk("s2_keep_out", 32'(out), 32'hB);
        chk("s2_overrun", 32'(overrun), 32'h1);
        chk("s2_still_valid", 32'(out_valid), 32'h1);
        out_ready = 1'b1;
        step();
        chk("s2_drain_valid", 32'(out_valid), 32'h0);
        chk("s2_overrun_sticky", 32'(overrun), 32'h1);

        // clr discards a partial word
        send(1'b1);
        send(1'b1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("s3_clr_no_valid", 32'(out_valid), 32'h0);
        send(1'b0);
        send(1'b1);
        send(1'b0);
        chk("s3_no_spurious", 32'(out_valid), 32'h0);
        send(1'b1);
        chk("s3_valid", 32'(out_valid), 32'h1);
        chk("s3_out", 32'(out), 32'h5);
        chk("s3_clr_keeps_overrun", 32'(overrun), 32'h1);
        step();

        // clr wins over en in the same cycle
        send(1'b1);
        clr = 1'b1;
        en  = 1'b1;
        in  = 1'b1;
        step();
        clr = 1'b0;
        en  = 1'b0;
        in  = 1'b0;
        send_word(4'b1011);
        chk("s3b_clr_wins_out", 32'(out), 32'hB);
        chk("s3b_clr_wins_valid", 32'(out_valid), 32'h1);
        step();

        // en gaps of two cycles between bits
        send(1'b1); step(); step();
        send(1'b0); step(); step();
        send(1'b1); step(); step();
        chk("s4_gap_no_valid", 32'(out_valid), 32'h0);
        send(1'b1);
        chk("s4_valid", 32'(out_valid), 32'h1);
        chk("s4_out", 32'(out), 32'hB);
        step();
        chk("s4_drained", 32'(out_valid), 32'h0);

        // Back-to-back words, drain and reload on the same edge
        send_word(4'b1100);
        chk("b2b_w1", 32'(out), 32'hC);
        send_word(4'b0011);
        chk("b2b_w2", 32'(out), 32'h3);
        chk("b2b_valid", 32'(out_valid), 32'h1);
        step();

        // Reset mid-word clears everything, including overrun
        send(1'b1);
        send(1'b1);
        send(1'b1);
        rst = 1'b1;
        en  = 1'b1;
        in  = 1'b1;
        step();
        rst = 1'b0;
        en  = 1'b0;
        in  = 1'b0;
        chk("s5_rst_out", 32'(out), 32'h0);
        chk("s5_rst_valid", 32'(out_valid), 32'h0);
        chk("s5_rst_overrun", 32'(overrun), 32'h0);
        send(1'b0);
        chk("s5_partial_discarded", 32'(out_valid), 32'h0);
        send(1'b1);
        send(1'b1);
        send(1'b0);
        chk("s5_out", 32'(out), 32'h6);
        chk("s5_valid", 32'(out_valid), 32'h1);
        step();

`ifdef SIPO_PARITY_EN
        // Even parity: 1011 has odd ones, parity bit 1 is correct
        send_word(4'b1011);
        chk("par_wait_parity", 32'(out_valid), 32'h0);
        send(1'b1);
        chk("par_ok_valid", 32'(out_valid), 32'h1);
        chk("par_ok_out", 32'(out), 32'hB);
        chk("par_ok_err", 32'(parity_err), 32'h0);
        step();
        send_word(4'b1011);
        send(1'b0);
        chk("par_bad_out", 32'(out), 32'hB);
        chk("par_bad_err", 32'(parity_err), 32'h1);
        step();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
